// File: rtl/dds_pkg.sv
// Shared definitions for the DDS phase generator and the sine lookup side.
// Holds the default widths and the controller state encoding.
package dds_pkg;

  localparam int DDS_ACC_WIDTH  = 24;
  localparam int DDS_ADDR_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    ARMED = 2'd2
  } dds_state_e;

endpackage

// File: rtl/dds_quarter_fold.sv
// Folds a full-wave phase address onto a quarter-wave table index plus sign.
// Purely combinational so the lookup side can reuse it.
module dds_quarter_fold
  import dds_pkg::*;
#(
  parameter int ADDR_WIDTH = DDS_ADDR_WIDTH
) (
  input  logic [ADDR_WIDTH-1:0] phase_addr,
  output logic [ADDR_WIDTH-3:0] quad_idx,
  output logic                  quad_negate
);

  logic [1:0]            quadrant;
  logic [ADDR_WIDTH-3:0] offset;

  // Odd quadrants walk the table backwards; the upper half-wave is negative.
  always_comb begin
    quadrant    = phase_addr[ADDR_WIDTH-1 -: 2];
    offset      = phase_addr[ADDR_WIDTH-3:0];
    quad_idx    = quadrant[0] ? ~offset : offset;
    quad_negate = quadrant[1];
  end

endmodule

// File: rtl/dds_phase_gen.sv
// Phase accumulator with handshaked frequency/phase configuration, optionally
// deferred to the next wrap, producing a registered, quarter-wave-folded address.
module dds_phase_gen
  import dds_pkg::*;
#(
  parameter int ACC_WIDTH  = DDS_ACC_WIDTH,
  parameter int ADDR_WIDTH = DDS_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  clear,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [ACC_WIDTH-1:0]  cfg_ftw,
  input  logic [ADDR_WIDTH-1:0] cfg_phase,
  input  logic                  cfg_on_wrap,
  output logic [ADDR_WIDTH-1:0] phase_addr,
  output logic [ADDR_WIDTH-3:0] quad_idx,
  output logic                  quad_negate,
  output logic                  addr_valid,
  output logic                  wrap
);

  dds_state_e            state_q, state_d;
  logic [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic                  carry_q, carry_d;
  logic [ACC_WIDTH-1:0]  ftw_q, ftw_d;
  logic [ADDR_WIDTH-1:0] phase_q, phase_d;
  logic [ACC_WIDTH-1:0]  stg_ftw_q, stg_ftw_d;
  logic [ADDR_WIDTH-1:0] stg_phase_q, stg_phase_d;
  logic [ADDR_WIDTH-1:0] phase_addr_q, phase_addr_d;
  logic [ADDR_WIDTH-3:0] quad_idx_q, quad_idx_d;
  logic                  quad_negate_q, quad_negate_d;
  logic                  addr_valid_q, addr_valid_d;
  logic                  wrap_q, wrap_d;
  logic                  cfg_ready_q, cfg_ready_d;

  logic                  handshake;
  logic                  active;
  logic                  load_now;
  logic                  apply_stage;
  logic                  stage_cfg;
  logic [ACC_WIDTH:0]    sum_ext;
  logic [ADDR_WIDTH-1:0] raw_addr;
  logic [ADDR_WIDTH-3:0] fold_idx;
  logic                  fold_negate;

  dds_quarter_fold #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_fold (
    .phase_addr (raw_addr),
    .quad_idx   (fold_idx),
    .quad_negate(fold_negate)
  );

  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    carry_d       = 1'b0;
    ftw_d         = ftw_q;
    phase_d       = phase_q;
    stg_ftw_d     = stg_ftw_q;
    stg_phase_d   = stg_phase_q;
    phase_addr_d  = phase_addr_q;
    quad_idx_d    = quad_idx_q;
    quad_negate_d = quad_negate_q;
    load_now      = 1'b0;
    apply_stage   = 1'b0;
    stage_cfg     = 1'b0;

    handshake = cfg_valid & cfg_ready_q;
    active    = (state_q != IDLE);
    sum_ext   = {1'b0, acc_q} + {1'b0, ftw_q};
    raw_addr  = acc_q[ACC_WIDTH-1 -: ADDR_WIDTH] + phase_q;

    // A deferred request only makes sense while the accumulator keeps running
    // uninterrupted; otherwise it degrades to an immediate load.
    case (state_q)
      IDLE: begin
        load_now = handshake;
        if (enable) state_d = RUN;
      end
      RUN: begin
        if (handshake) begin
          if (cfg_on_wrap && enable && !clear) begin
            stage_cfg = 1'b1;
            state_d   = ARMED;
          end else begin
            load_now = 1'b1;
          end
        end
        if (!enable) state_d = IDLE;
      end
      ARMED: begin
        apply_stage = !enable || clear || carry_q;
        if (!enable) state_d = IDLE;
        else if (clear || carry_q) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase

    if (load_now) begin
      ftw_d   = cfg_ftw;
      phase_d = cfg_phase;
    end
    if (apply_stage) begin
      ftw_d   = stg_ftw_q;
      phase_d = stg_phase_q;
    end
    if (stage_cfg) begin
      stg_ftw_d   = cfg_ftw;
      stg_phase_d = cfg_phase;
    end

    if (clear) begin
      acc_d = '0;
    end else if (active) begin
      acc_d   = sum_ext[ACC_WIDTH-1:0];
      carry_d = sum_ext[ACC_WIDTH];
    end

    if (active) begin
      phase_addr_d  = raw_addr;
      quad_idx_d    = fold_idx;
      quad_negate_d = fold_negate;
    end
    addr_valid_d = active;
    wrap_d       = carry_q & active;
    cfg_ready_d  = (state_d != ARMED);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      acc_q         <= '0;
      carry_q       <= 1'b0;
      ftw_q         <= '0;
      phase_q       <= '0;
      stg_ftw_q     <= '0;
      stg_phase_q   <= '0;
      phase_addr_q  <= '0;
      quad_idx_q    <= '0;
      quad_negate_q <= 1'b0;
      addr_valid_q  <= 1'b0;
      wrap_q        <= 1'b0;
      cfg_ready_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      carry_q       <= carry_d;
      ftw_q         <= ftw_d;
      phase_q       <= phase_d;
      stg_ftw_q     <= stg_ftw_d;
      stg_phase_q   <= stg_phase_d;
      phase_addr_q  <= phase_addr_d;
      quad_idx_q    <= quad_idx_d;
      quad_negate_q <= quad_negate_d;
      addr_valid_q  <= addr_valid_d;
      wrap_q        <= wrap_d;
      cfg_ready_q   <= cfg_ready_d;
    end
  end

  assign cfg_ready   = cfg_ready_q;
  assign phase_addr  = phase_addr_q;
  assign quad_idx    = quad_idx_q;
  assign quad_negate = quad_negate_q;
  assign addr_valid  = addr_valid_q;
  assign wrap        = wrap_q;

endmodule

// File: tb/tb_dds_phase_gen.sv
// Scoreboard bench for dds_phase_gen: expected addresses are queued when a
// scenario is set up and popped whenever the DUT presents a valid address.
module tb_dds_phase_gen;

  localparam int ACC_W  = 24;
  localparam int ADDR_W = 8;
  localparam int QSIZE  = 64;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              enable = 1'b0;
  logic              clear = 1'b0;
  logic              cfg_valid = 1'b0;
  logic              cfg_on_wrap = 1'b0;
  logic [ACC_W-1:0]  cfg_ftw = '0;
  logic [ADDR_W-1:0] cfg_phase = '0;
  logic              cfg_ready;
  logic [ADDR_W-1:0] phase_addr;
  logic [ADDR_W-3:0] quad_idx;
  logic              quad_negate;
  logic              addr_valid;
  logic              wrap;

  int checkCount = 0;
  int errorCount = 0;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-3:0] idx;
    logic              neg;
    logic              wrp;
  } exp_t;

  exp_t sbQ[$];

  dds_phase_gen #(
    .ACC_WIDTH (ACC_W),
    .ADDR_WIDTH(ADDR_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .clear      (clear),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_ftw    (cfg_ftw),
    .cfg_phase  (cfg_phase),
    .cfg_on_wrap(cfg_on_wrap),
    .phase_addr (phase_addr),
    .quad_idx   (quad_idx),
    .quad_negate(quad_negate),
    .addr_valid (addr_valid),
    .wrap       (wrap)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic pushFull(input int a, input int idx, input bit neg, input bit w);
    exp_t e;
    e.addr = a[ADDR_W-1:0];
    e.idx  = idx[ADDR_W-3:0];
    e.neg  = neg;
    e.wrp  = w;
    sbQ.push_back(e);
  endtask

  // Expected fold derived arithmetically from the quadrant number.
  task automatic pushExp(input int a, input bit w);
    int quarter;
    int offs;
    quarter = (a % 256) / QSIZE;
    offs    = a % QSIZE;
    pushFull(a % 256, (quarter % 2 == 1) ? (QSIZE - 1 - offs) : offs, quarter >= 2, w);
  endtask

  always @(negedge clk) begin
    if (rst_n && addr_valid && sbQ.size() > 0) begin
      exp_t e;
      e = sbQ.pop_front();
      checkOutput("phase_addr", 32'(phase_addr), 32'(e.addr));
      checkOutput("quad_idx", 32'(quad_idx), 32'(e.idx));
      checkOutput("quad_negate", 32'(quad_negate), 32'(e.neg));
      checkOutput("wrap", 32'(wrap), 32'(e.wrp));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit en, input bit clr, input bit cv,
                               input logic [ACC_W-1:0] ftw, input logic [ADDR_W-1:0] ph,
                               input bit onw);
    enable      = en;
    clear       = clr;
    cfg_valid   = cv;
    cfg_ftw     = ftw;
    cfg_phase   = ph;
    cfg_on_wrap = onw;
  endtask

  task automatic releaseReset();
    #3;
    checkOutput("ready_in_reset", 32'(cfg_ready), 32'd0);
    rst_n = 1'b1;
    tick();
    checkOutput("ready_after_reset", 32'(cfg_ready), 32'd1);
  endtask

  task automatic doReset();
    applyStimulus(0, 0, 0, '0, '0, 0);
    sbQ.delete();
    rst_n = 1'b0;
    tick();
    tick();
    releaseReset();
  endtask

  task automatic waitDrain(input int maxCycles);
    int n;
    n = 0;
    while (sbQ.size() > 0 && n < maxCycles) begin
      tick();
      n++;
    end
    checkOutput("drain_timeout", 32'(sbQ.size()), 32'd0);
  endtask

  // Loads a configuration from IDLE and enables; first valid address follows
  // two edges later.
  task automatic startRun(input logic [ACC_W-1:0] ftw, input logic [ADDR_W-1:0] ph);
    applyStimulus(0, 0, 1, ftw, ph, 0);
    tick();
    applyStimulus(1, 0, 0, '0, '0, 0);
    tick();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lowCount;

    // Reset values while rst_n is held low.
    rst_n = 1'b0;
    #2;
    checkOutput("reset_phase_addr", 32'(phase_addr), 32'd0);
    checkOutput("reset_addr_valid", 32'(addr_valid), 32'd0);
    checkOutput("reset_wrap", 32'(wrap), 32'd0);

    // Full sweep at step 1 with a single wrap back to address 0.
    doReset();
    startRun(24'h010000, 8'h00);
    for (int a = 0; a < 256; a++) pushExp(a, 0);
    pushExp(0, 1);
    pushExp(1, 0);
    checkOutput("valid_before_first", 32'(addr_valid), 32'd0);
    tick();
    checkOutput("valid_first", 32'(addr_valid), 32'd1);
    waitDrain(300);
    applyStimulus(0, 0, 0, '0, '0, 0);
    tick();
    tick();
    checkOutput("valid_after_disable", 32'(addr_valid), 32'd0);

    // Quarter step exercises every quadrant of the fold.
    doReset();
    pushFull(0, 0, 0, 0);
    pushFull(64, 63, 0, 0);
    pushFull(128, 0, 1, 0);
    pushFull(192, 63, 1, 0);
    pushFull(0, 0, 0, 1);
    startRun(24'h400000, 8'h00);
    waitDrain(20);

    // Deferred retune: ready stays low until the wrap, then step doubles.
    doReset();
    for (int a = 0; a < 256; a += 16) pushExp(a, 0);
    pushExp(0, 1);
    pushExp(16, 0);
    pushExp(48, 0);
    pushExp(80, 0);
    pushExp(112, 0);
    startRun(24'h100000, 8'h00);
    tick();
    tick();
    tick();
    applyStimulus(1, 0, 1, 24'h200000, 8'h00, 1);
    tick();
    applyStimulus(1, 0, 0, '0, '0, 0);
    lowCount = 0;
    while (cfg_ready == 1'b0 && lowCount < 50) begin
      lowCount++;
      tick();
    end
    checkOutput("armed_ready_low_cycles", 32'(lowCount), 32'd13);
    waitDrain(40);

    // Zero step with a half-wave phase offset: constant, negated, never wraps.
    doReset();
    for (int k = 0; k < 8; k++) pushExp(8'h80, 0);
    startRun(24'h000000, 8'h80);
    waitDrain(20);

    // Clear and immediate retune in the same cycle.
    doReset();
    for (int a = 0; a < 4; a++) pushExp(a, 0);
    pushExp(0, 0);
    pushExp(2, 0);
    pushExp(4, 0);
    pushExp(6, 0);
    startRun(24'h010000, 8'h00);
    tick();
    tick();
    tick();
    applyStimulus(1, 1, 1, 24'h020000, 8'h00, 0);
    tick();
    applyStimulus(1, 0, 0, '0, '0, 0);
    waitDrain(20);

    // Asynchronous reset while ARMED discards the staged word.
    doReset();
    startRun(24'h100000, 8'h00);
    tick();
    tick();
    tick();
    applyStimulus(1, 0, 1, 24'h200000, 8'h00, 1);
    tick();
    applyStimulus(1, 0, 0, '0, '0, 0);
    tick();
    tick();
    checkOutput("armed_ready", 32'(cfg_ready), 32'd0);
    checkOutput("armed_addr_nonzero", 32'(phase_addr != 0), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_phase_addr", 32'(phase_addr), 32'd0);
    checkOutput("async_quad_idx", 32'(quad_idx), 32'd0);
    checkOutput("async_quad_negate", 32'(quad_negate), 32'd0);
    checkOutput("async_addr_valid", 32'(addr_valid), 32'd0);
    checkOutput("async_wrap", 32'(wrap), 32'd0);
    checkOutput("async_cfg_ready", 32'(cfg_ready), 32'd0);
    applyStimulus(0, 0, 0, '0, '0, 0);
    tick();
    releaseReset();
    for (int k = 0; k < 24; k++) pushExp(0, 0);
    applyStimulus(1, 0, 0, '0, '0, 0);
    tick();
    waitDrain(40);
    checkOutput("post_reset_ready", 32'(cfg_ready), 32'd1);

    applyStimulus(0, 0, 0, '0, '0, 0);
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
